sign_ext: RTL and testbench

- Immediate-extension unit for the 32-bit datapath.
- Widens a 16-bit instruction immediate to the datapath width. Supports sign extension (default), zero extension, upper-half placement (LUI) and sign extension with word-offset shift (branches).
- Provides a combinational result for single-cycle use and a registered copy with valid flag for pipelined use.

---
 rtl/sign_ext_if.sv | 20 ++
 rtl/sign_ext.sv | 29 ++
 tb/tb_sign_ext.sv | 113 +++++++++++
 3 files changed

// File: rtl/sign_ext_if.sv
// sign_ext_if: bus between the immediate-extension unit and its user.
//   immediate  raw IN_WIDTH-bit immediate field
//   mode       00 sign, 01 zero, 10 upper, 11 sign shifted left 2
//   in_valid   qualifies immediate/mode for capture into the registered path
//   extended   combinational WIDTH-bit result
//   extended_q registered copy of extended
//   out_valid  extended_q holds a result captured from a valid input
interface sign_ext_if #(
   parameter int WIDTH    = 32,
   parameter int IN_WIDTH = 16
);
   logic [IN_WIDTH-1:0] immediate;
   logic [1:0]          mode;
   logic                in_valid;
   logic [WIDTH-1:0]    extended;
   logic [WIDTH-1:0]    extended_q;
   logic                out_valid;
   modport master (output immediate, mode, in_valid, input extended, extended_q, out_valid);
   modport slave  (input immediate, mode, in_valid, output extended, extended_q, out_valid);
endinterface

// File: rtl/sign_ext.sv
// sign_ext: widens a 16-bit immediate to the datapath width, combinational and registered.
//   clk    rising-edge clock for the registered path
//   rst_n  asynchronous active-low reset of extended_q/out_valid
//   bus    sign_ext_if slave: immediate, mode, in_valid in; extended, extended_q, out_valid out
module sign_ext #(
   parameter int WIDTH    = 32,
   parameter int IN_WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   sign_ext_if.slave  bus
);
   localparam int PAD = WIDTH - IN_WIDTH;
   logic [WIDTH-1:0] sx, zx, up;
   assign sx = {{PAD{bus.immediate[IN_WIDTH-1]}}, bus.immediate};
   assign zx = {{PAD{1'b0}}, bus.immediate};
   assign up = {bus.immediate, {PAD{1'b0}}};
   // branch mode drops the top two bits of the sign-extended value
   assign bus.extended = bus.mode[1] ? (bus.mode[0] ? {sx[WIDTH-3:0], 2'b00} : up)
                                     : (bus.mode[0] ? zx : sx);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.extended_q <= '0;
         bus.out_valid  <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) bus.extended_q <= bus.extended;
      end
endmodule

// File: tb/tb_sign_ext.sv
// tb_sign_ext: randomized and directed self-checking bench for sign_ext.
module tb_sign_ext;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q;
   logic        exp_v;
   sign_ext_if #(.WIDTH(32), .IN_WIDTH(16)) bus ();
   sign_ext #(.WIDTH(32), .IN_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [31:0] model(logic [15:0] imm, logic [1:0] m);
      longint s, r;
      s = imm[15] ? longint'(imm) - 65536 : longint'(imm);
      case (m)
         2'b00:   r = s;
         2'b01:   r = longint'(imm);
         2'b10:   r = longint'(imm) * 65536;
         default: r = s * 4;
      endcase
      return r[31:0];
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic comb(input string tag, input logic [15:0] imm, input logic [1:0] m);
      bus.immediate = imm;
      bus.mode = m;
      #1 chk(tag, bus.extended, model(imm, m));
   endtask
   task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] m);
      @(negedge clk);
      bus.in_valid = v;
      bus.immediate = imm;
      bus.mode = m;
      if (v) exp_q = model(imm, m);
      exp_v = v;
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.immediate = '0;
      bus.mode = 2'b00;
      exp_q = '0;
      exp_v = 1'b0;
      #2;
      chk("rst_q", bus.extended_q, 32'h0);
      chk("rst_v", {31'b0, bus.out_valid}, 32'h0);
      // directed combinational cases, applied while still in reset
      comb("sx0000", 16'h0000, 2'b00); #9;
      comb("sx0001", 16'h0001, 2'b00); #9;
      comb("sx0008", 16'h0008, 2'b00); #9;
      comb("sx8000", 16'h8000, 2'b00); #9;
      chk("sx8000_lit", bus.extended, 32'hFFFF8000);
      comb("sx7fff", 16'h7FFF, 2'b00);
      chk("sx7fff_lit", bus.extended, 32'h00007FFF);
      comb("sxffff", 16'hFFFF, 2'b00);
      comb("zx8000", 16'h8000, 2'b01);
      chk("zx8000_lit", bus.extended, 32'h00008000);
      comb("up1234", 16'h1234, 2'b10);
      chk("up1234_lit", bus.extended, 32'h12340000);
      comb("brffff", 16'hFFFF, 2'b11);
      chk("brffff_lit", bus.extended, 32'hFFFFFFFC);
      comb("br0004", 16'h0004, 2'b11);
      chk("br0004_lit", bus.extended, 32'h00000010);
      comb("br7fff", 16'h7FFF, 2'b11);
      comb("up8001", 16'h8001, 2'b10);
      for (int i = 0; i < 40; i++)
         comb("rand_comb", 16'($urandom), 2'($urandom));
      chk("rst_hold_q", bus.extended_q, 32'h0);
      chk("rst_hold_v", {31'b0, bus.out_valid}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 16'h8000, 2'b00);
      chk("cap_q", bus.extended_q, 32'hFFFF8000);
      chk("cap_v", {31'b0, bus.out_valid}, 32'h1);
      drive(1'b0, 16'h1234, 2'b10);
      chk("hold_q", bus.extended_q, 32'hFFFF8000);
      chk("hold_v", {31'b0, bus.out_valid}, 32'h0);
      drive(1'b1, 16'h00FF, 2'b01);
      chk("pre_rst_v", {31'b0, bus.out_valid}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_q", bus.extended_q, 32'h0);
      chk("async_v", {31'b0, bus.out_valid}, 32'h0);
      comb("rst_comb", 16'hABCD, 2'b00);
      exp_q = '0;
      exp_v = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 16'h0001, 2'b00);
      chk("b2b0_q", bus.extended_q, 32'h00000001);
      chk("b2b0_v", {31'b0, bus.out_valid}, 32'h1);
      drive(1'b1, 16'h8000, 2'b00);
      chk("b2b1_q", bus.extended_q, 32'hFFFF8000);
      chk("b2b1_v", {31'b0, bus.out_valid}, 32'h1);
      drive(1'b1, 16'hFFFF, 2'b00);
      chk("b2b2_q", bus.extended_q, 32'hFFFFFFFF);
      chk("b2b2_v", {31'b0, bus.out_valid}, 32'h1);
      for (int i = 0; i < 60; i++) begin
         drive(1'($urandom), 16'($urandom), 2'($urandom));
         chk("rand_q", bus.extended_q, exp_q);
         chk("rand_v", {31'b0, bus.out_valid}, {31'b0, exp_v});
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
